// File: rtl/mesh_noc_pkg.sv
// Shared definitions for the mesh router: port indices, flit layout, and the
// dimension-ordered route / destination-legality helpers.
package mesh_noc_pkg;

    localparam int NPORTS  = 5;
    localparam int FLIT_W  = 64;
    localparam int COORD_W = 16;

    localparam int DX_LSB  = 48;
    localparam int DY_LSB  = 32;
    localparam int PAY_W   = 32;

    typedef logic [2:0] port_t;

    localparam port_t P_LOCAL = 3'd0;
    localparam port_t P_LEFT  = 3'd1;
    localparam port_t P_RIGHT = 3'd2;
    localparam port_t P_UP    = 3'd3;
    localparam port_t P_DOWN  = 3'd4;

    typedef struct packed {
        logic [COORD_W-1:0] dst_x;
        logic [COORD_W-1:0] dst_y;
        logic [PAY_W-1:0]   payload;
    } flit_t;

    // X is resolved before Y so that routes are deadlock free on the mesh
    function automatic port_t route_port(input logic [COORD_W-1:0] dx,
                                         input logic [COORD_W-1:0] dy,
                                         input logic [COORD_W-1:0] mx,
                                         input logic [COORD_W-1:0] my);
        if (dx > mx)      return P_RIGHT;
        else if (dx < mx) return P_LEFT;
        else if (dy > my) return P_DOWN;
        else if (dy < my) return P_UP;
        else              return P_LOCAL;
    endfunction

    function automatic logic dst_legal(input logic [COORD_W-1:0] dx,
                                       input logic [COORD_W-1:0] dy,
                                       input logic [COORD_W-1:0] max_x,
                                       input logic [COORD_W-1:0] max_y);
        return (dx != '0) && (dy != '0) && (dx <= max_x) && (dy <= max_y);
    endfunction

endpackage

// File: rtl/mesh_rr_arbiter.sv
// Five-request round-robin arbiter. The pointer marks the highest-priority
// requester and moves to winner+1 only when the grant is actually consumed.
module mesh_rr_arbiter
    import mesh_noc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req,
    input  logic              adv,
    output logic [NPORTS-1:0] gnt,
    output port_t             winner
);

    port_t ptr;
    logic  found;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NPORTS) j = j - NPORTS;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                winner = port_t'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= P_LOCAL;
        end else if (adv && found) begin
            ptr <= (winner == port_t'(NPORTS-1)) ? P_LOCAL : port_t'(winner + 3'd1);
        end
    end

endmodule

// File: rtl/mesh_router_arbiter.sv
// Mesh node switch allocator: per-input FIFOs, XY routing, per-output RR
// arbitration and output registers. Optional drop counter: MESH_ARB_DROP_CNT_EN.
module mesh_router_arbiter
    import mesh_noc_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MESH_X     = 3,
    parameter int MESH_Y     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COORD_W-1:0]             my_x,
    input  logic [COORD_W-1:0]             my_y,
    input  logic [NPORTS-1:0]              in_valid,
    input  logic [NPORTS-1:0][FLIT_W-1:0]  in_flit,
    output logic [NPORTS-1:0]              in_ready,
    output logic [NPORTS-1:0]              out_valid,
    output logic [NPORTS-1:0][FLIT_W-1:0]  out_flit,
    input  logic [NPORTS-1:0]              out_ready,
    output logic [7:0]                     drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(MESH_X);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(MESH_Y);

    flit_t                        mem [NPORTS][FIFO_DEPTH];
    logic [AW-1:0]                rd_ptr [NPORTS];
    logic [AW-1:0]                wr_ptr [NPORTS];
    logic [CW-1:0]                count  [NPORTS];

    flit_t [NPORTS-1:0]           head;
    logic  [NPORTS-1:0]           head_vld;
    logic  [NPORTS-1:0]           legal;
    logic  [NPORTS-1:0]           drop;
    port_t [NPORTS-1:0]           dir;
    logic  [NPORTS-1:0][NPORTS-1:0] req_m;   // [output][input]
    logic  [NPORTS-1:0][NPORTS-1:0] gnt_m;   // [output][input]
    port_t [NPORTS-1:0]           winner;
    logic  [NPORTS-1:0]           load;
    logic  [NPORTS-1:0]           push;
    logic  [NPORTS-1:0]           pop;

    // in_ready looks only at the registered count, never at out_ready
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            in_ready[i] = (count[i] < CW'(FIFO_DEPTH));
            push[i]     = in_valid[i] && in_ready[i];
        end
    end

    always_comb begin
        head     = '0;
        head_vld = '0;
        legal    = '0;
        drop     = '0;
        dir      = '0;
        req_m    = '0;
        load     = '0;
        for (int i = 0; i < NPORTS; i++) begin
            head[i]     = mem[i][rd_ptr[i]];
            head_vld[i] = (count[i] != '0);
            legal[i]    = dst_legal(head[i].dst_x, head[i].dst_y, MAX_X, MAX_Y);
            drop[i]     = head_vld[i] && !legal[i];
            dir[i]      = route_port(head[i].dst_x, head[i].dst_y, my_x, my_y);
            for (int o = 0; o < NPORTS; o++)
                req_m[o][i] = head_vld[i] && legal[i] && (dir[i] == port_t'(o));
        end
        for (int o = 0; o < NPORTS; o++)
            load[o] = (!out_valid[o] || out_ready[o]) && (|req_m[o]);
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        mesh_rr_arbiter u_arb (
            .clk    (clk),
            .rst    (rst),
            .req    (req_m[o]),
            .adv    (load[o]),
            .gnt    (gnt_m[o]),
            .winner (winner[o])
        );
    end

    // A head leaves its FIFO either as a drop or as a granted, loaded flit
    always_comb begin
        pop = drop;
        for (int o = 0; o < NPORTS; o++)
            for (int i = 0; i < NPORTS; i++)
                if (gnt_m[o][i] && load[o]) pop[i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= flit_t'(in_flit[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPORTS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= '0;
            out_flit  <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (load[o]) begin
                    out_valid[o] <= 1'b1;
                    out_flit[o]  <= head[winner[o]];
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

`ifdef MESH_ARB_DROP_CNT_EN
    logic [7:0] drop_q;
    logic [3:0] ndrop;
    logic [8:0] drop_sum;

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NPORTS; i++) ndrop = ndrop + 4'(drop[i]);
        drop_sum = {1'b0, drop_q} + 9'(ndrop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_q <= '0;
        else      drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mesh_router_arbiter.sv
// Self-checking bench for mesh_router_arbiter: directed scenarios plus a
// randomized run scored against a per-(source,output) in-order queue model.
module tb_mesh_router_arbiter;

    localparam int NP = 5;
`ifdef MESH_ARB_DROP_CNT_EN
    localparam bit DCNT = 1'b1;
`else
    localparam bit DCNT = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [15:0]           my_x = 16'd2;
    logic [15:0]           my_y = 16'd2;
    logic [NP-1:0]         in_valid = '0;
    logic [NP-1:0][63:0]   in_flit = '0;
    logic [NP-1:0]         in_ready;
    logic [NP-1:0]         out_valid;
    logic [NP-1:0][63:0]   out_flit;
    logic [NP-1:0]         out_ready = '1;
    logic [7:0]            drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [63:0]           expq [NP][NP][$];
    int                    ndrop;
    logic [NP-1:0]         pv, pr;
    logic [NP-1:0][63:0]   pf;

    always #5 clk = ~clk;

    mesh_router_arbiter #(.FIFO_DEPTH(2), .MESH_X(3), .MESH_Y(3)) dut (
        .clk(clk), .rst(rst), .my_x(my_x), .my_y(my_y),
        .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
        .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
        .drop_cnt(drop_cnt)
    );

    function automatic logic [63:0] mk(input int x, input int y, input logic [31:0] p);
        return {16'(x), 16'(y), p};
    endfunction

    function automatic bit ref_legal(input logic [63:0] f);
        int dx, dy;
        dx = int'(f[63:48]);
        dy = int'(f[47:32]);
        return dx >= 1 && dx <= 3 && dy >= 1 && dy <= 3;
    endfunction

    function automatic int ref_route(input logic [63:0] f);
        int dx, dy, mx, my;
        dx = int'(f[63:48]);
        dy = int'(f[47:32]);
        mx = int'(my_x);
        my = int'(my_y);
        if (dx != mx) return (dx > mx) ? 2 : 1;
        if (dy != my) return (dy > my) ? 4 : 3;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int x, input int y);
        rst = 1'b0; in_valid = '0; in_flit = '0; out_ready = '1;
        my_x = 16'(x); my_y = 16'(y);
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = '0; out_ready = '1; my_x = 16'd2; my_y = 16'd2;
        #1;
        checks++; if (in_ready !== 5'h1f) begin errors++; $display("FAIL reset_in_ready got=%h want=1f", in_ready); end
        checks++; if (out_valid !== 5'h00) begin errors++; $display("FAIL reset_out_valid got=%h want=00", out_valid); end
        checks++; if (out_flit !== '0) begin errors++; $display("FAIL reset_out_flit got=%h want=0", out_flit); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_straight();
        logic [63:0] f;
        f = mk(3, 2, 32'hA5);
        in_valid[0] = 1'b1; in_flit[0] = f;
        tick();
        in_valid = '0;
        checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL straight_early got=%b want=00000", out_valid); end
        tick();
        checks++; if (out_valid !== 5'b00100) begin errors++; $display("FAIL straight_valid got=%b want=00100", out_valid); end
        checks++; if (out_flit[2] !== f) begin errors++; $display("FAIL straight_flit got=%h want=%h", out_flit[2], f); end
        tick();
        checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL straight_done got=%b want=00000", out_valid); end
    endtask

    task automatic test_contention();
        logic [63:0] want [4];
        do_reset(2, 2);
        want[0] = mk(2, 2, 32'h11); want[1] = mk(2, 2, 32'h33);
        want[2] = mk(2, 2, 32'h12); want[3] = mk(2, 2, 32'h34);
        in_valid = 5'b01010; in_flit[1] = want[0]; in_flit[3] = want[1];
        tick();
        in_flit[1] = want[2]; in_flit[3] = want[3];
        tick();
        in_valid = '0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 5'b00001 || out_flit[0] !== want[k]) begin
                errors++;
                $display("FAIL contention_%0d got v=%b f=%h want v=00001 f=%h", k, out_valid, out_flit[0], want[k]);
            end
            tick();
        end
        checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL contention_idle got=%b want=00000", out_valid); end
    endtask

    task automatic test_backpressure();
        int acc;
        logic [63:0] got [$];
        do_reset(2, 2);
        out_ready = 5'b11011;
        acc = 0;
        in_valid[0] = 1'b1; in_flit[0] = mk(3, 2, 32'h100);
        repeat (8) begin
            if (in_ready[0]) acc++;
            tick();
            in_flit[0] = mk(3, 2, 32'h100 + acc);
        end
        in_valid = '0;
        checks++; if (acc !== 3) begin errors++; $display("FAIL bp_accepted got=%0d want=3", acc); end
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", in_ready[0]); end
        checks++; if (out_valid[2] !== 1'b1 || out_flit[2] !== mk(3, 2, 32'h100)) begin
            errors++; $display("FAIL bp_held got v=%b f=%h want v=1 f=%h", out_valid[2], out_flit[2], mk(3, 2, 32'h100));
        end
        out_ready = '1;
        repeat (10) begin
            if (out_valid[2]) got.push_back(out_flit[2]);
            tick();
        end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL bp_drain_count got=%0d want=3", got.size()); end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            checks++;
            if (got[k] !== mk(3, 2, 32'h100 + k)) begin
                errors++; $display("FAIL bp_order_%0d got=%h want=%h", k, got[k], mk(3, 2, 32'h100 + k));
            end
        end
    endtask

    task automatic test_yroute();
        in_valid = 5'b01110;
        in_flit[2] = mk(2, 1, 32'h21);
        in_flit[1] = mk(2, 3, 32'h13);
        in_flit[3] = mk(1, 3, 32'h31);
        tick();
        in_valid = '0;
        tick();
        checks++; if (out_valid !== 5'b11010) begin errors++; $display("FAIL yroute_valid got=%b want=11010", out_valid); end
        checks++; if (out_flit[3] !== mk(2, 1, 32'h21)) begin errors++; $display("FAIL yroute_up got=%h want=%h", out_flit[3], mk(2, 1, 32'h21)); end
        checks++; if (out_flit[4] !== mk(2, 3, 32'h13)) begin errors++; $display("FAIL yroute_down got=%h want=%h", out_flit[4], mk(2, 3, 32'h13)); end
        checks++; if (out_flit[1] !== mk(1, 3, 32'h31)) begin errors++; $display("FAIL yroute_left got=%h want=%h", out_flit[1], mk(1, 3, 32'h31)); end
        tick();
    endtask

    task automatic test_drop();
        int acc, want;
        do_reset(2, 2);
        in_valid[4] = 1'b1; in_flit[4] = mk(0, 2, 32'hD0);
        tick();
        in_valid = '0;
        repeat (3) begin
            checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL drop_no_out got=%b want=00000", out_valid); end
            tick();
        end
        want = DCNT ? 1 : 0;
        checks++; if (int'(drop_cnt) !== want) begin errors++; $display("FAIL drop_one got=%0d want=%0d", drop_cnt, want); end
        acc = 0;
        in_valid[4] = 1'b1;
        for (int k = 0; k < 310; k++) begin
            case (k % 5)
                0: in_flit[4] = mk(0, 1, k);
                1: in_flit[4] = mk(2, 0, k);
                2: in_flit[4] = mk(4, 2, k);
                3: in_flit[4] = mk(1, 4, k);
                default: in_flit[4] = mk(16'hFFFF, 2, k);
            endcase
            if (in_ready[4]) acc++;
            tick();
            if (out_valid !== 5'b00000) begin
                checks++; errors++; $display("FAIL drop_stream_out got=%b want=00000", out_valid);
            end
        end
        in_valid = '0;
        repeat (4) tick();
        want = DCNT ? ((1 + acc > 255) ? 255 : 1 + acc) : 0;
        checks++; if (acc < 300) begin errors++; $display("FAIL drop_stream_accepted got=%0d want>=300", acc); end
        checks++; if (int'(drop_cnt) !== want) begin errors++; $display("FAIL drop_saturate got=%0d want=%0d", drop_cnt, want); end
    endtask

    task automatic rnd_cycle();
        logic [63:0] f, e;
        int src;
        for (int o = 0; o < NP; o++) begin
            if (pv[o] && !pr[o]) begin
                checks++;
                if (out_valid[o] !== 1'b1 || out_flit[o] !== pf[o]) begin
                    errors++; $display("FAIL rnd_hold_%0d got v=%b f=%h want v=1 f=%h", o, out_valid[o], out_flit[o], pf[o]);
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                f = in_flit[i];
                if (ref_legal(f)) expq[i][ref_route(f)].push_back(f);
                else ndrop++;
            end
        end
        for (int o = 0; o < NP; o++) begin
            if (out_valid[o] && out_ready[o]) begin
                src = int'(out_flit[o][31:29]);
                checks++;
                if (src >= NP || expq[src][o].size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected out=%0d got=%h", o, out_flit[o]);
                end else begin
                    e = expq[src][o].pop_front();
                    if (out_flit[o] !== e) begin
                        errors++; $display("FAIL rnd_order out=%0d got=%h want=%h", o, out_flit[o], e);
                    end
                end
            end
        end
        pv = out_valid; pr = out_ready; pf = out_flit;
        tick();
    endtask

    task automatic test_random();
        int seq, left, want, x, y;
        do_reset(1, 3);
        ndrop = 0; seq = 0; pv = '0; pr = '0; pf = '0;
        for (int i = 0; i < NP; i++) for (int o = 0; o < NP; o++) expq[i][o].delete();
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NP; i++) begin
                in_valid[i] = ($urandom_range(0, 99) < 60);
                x = $urandom_range(1, 3); y = $urandom_range(1, 3);
                if ($urandom_range(0, 99) < 12) begin
                    case ($urandom_range(0, 3))
                        0: x = 0;
                        1: x = 4;
                        2: y = 0;
                        default: y = 4;
                    endcase
                end
                in_flit[i] = mk(x, y, {3'(i), 29'(seq)});
                seq++;
            end
            for (int o = 0; o < NP; o++) out_ready[o] = ($urandom_range(0, 99) < 70);
            rnd_cycle();
        end
        in_valid = '0; out_ready = '1;
        repeat (40) rnd_cycle();
        left = 0;
        for (int i = 0; i < NP; i++) for (int o = 0; o < NP; o++) left += expq[i][o].size();
        checks++; if (left !== 0) begin errors++; $display("FAIL rnd_leftover got=%0d want=0", left); end
        want = DCNT ? ((ndrop > 255) ? 255 : ndrop) : 0;
        checks++; if (int'(drop_cnt) !== want) begin errors++; $display("FAIL rnd_drop_cnt got=%0d want=%0d", drop_cnt, want); end
    endtask

    task automatic test_midflight_reset();
        do_reset(2, 2);
        out_ready = '0;
        in_valid = '1;
        for (int i = 0; i < NP; i++) in_flit[i] = mk(1 + (i % 3), 1 + ((i + 1) % 3), 32'hEE00 + i);
        repeat (4) tick();
        checks++; if (out_valid === 5'b00000) begin errors++; $display("FAIL mid_prefill got=%b want=nonzero", out_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL mid_out_valid got=%b want=00000", out_valid); end
        checks++; if (out_flit !== '0) begin errors++; $display("FAIL mid_out_flit got=%h want=0", out_flit); end
        checks++; if (in_ready !== 5'h1f) begin errors++; $display("FAIL mid_in_ready got=%h want=1f", in_ready); end
        @(negedge clk);
        in_valid = '0; out_ready = '1;
        rst = 1'b1;
        tick();
        in_valid[0] = 1'b1; in_flit[0] = mk(1, 2, 32'hBEEF);
        tick();
        in_valid = '0;
        checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL mid_stale got=%b want=00000", out_valid); end
        tick();
        checks++; if (out_valid !== 5'b00010 || out_flit[1] !== mk(1, 2, 32'hBEEF)) begin
            errors++; $display("FAIL mid_first got v=%b f=%h want v=00010 f=%h", out_valid, out_flit[1], mk(1, 2, 32'hBEEF));
        end
        repeat (3) begin
            tick();
            checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL mid_after got=%b want=00000", out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_contention();
        test_backpressure();
        test_yroute();
        test_drop();
        test_random();
        test_midflight_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
